// File: rtl/seq_mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_shift_add
// Description : Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//               Signed or unsigned mode is chosen per operation. There is a
//               valid/ready handshake on the operand side and on the result
//               side. One partial product is retired per clock.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               in_valid/ready  - operand handshake (a, b, signed_mode)
//               a, b            - multiplicand / multiplier, WIDTH bits
//               signed_mode     - 1: two's complement, 0: unsigned
//               out_valid/ready - result handshake
//               p               - product, 2*WIDTH bits
//               busy            - high while the product is being formed
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_shift_add #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int                c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_p;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_neg;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_addend;

    // Magnitudes are kept as WIDTH-bit unsigned values: negating the most
    // negative operand yields 2^(WIDTH-1), which is still representable.
    assign w_a_mag  = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign w_neg    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

    // Partial product for the current bit position of the multiplicand.
    assign w_addend = {{WIDTH{1'b0}}, r_mplier} << r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_p         <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= w_a_mag;
                        r_mplier   <= w_b_mag;
                        r_neg      <= w_neg;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    // The multiplicand shifts right so its LSB always
                    // selects the partial product for bit position r_cnt.
                    if (r_mcand[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_mcand <= r_mcand >> 1;
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    // Sign is re-applied once on the full-width magnitude;
                    // negating zero gives zero, so no -0 can appear.
                    r_p         <= r_neg ? -r_acc : r_acc;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign p         = r_p;

endmodule
`default_nettype wire
